hpm_err_monitor: RTL
====================

Name: hpm_err_monitor

Overview:
Downstream companion to the approximate half-precision multiplier (hpm). Consumes each operand pair and the approximate product, and computes the exact truncated IEEE-754 half product internally. Measures the ULP distance between the two and accumulates per-window error statistics, which the ILA probes. Three-stage pipeline, one sample per clock, no backpressure.

Parameters:
WINDOW, 16, samples per measurement window (matches the 16-entry operand BRAMs); 1..65535
THRESH, 4, ULP distance above which a sample counts as "exceeding"
SUM_W, 24, width of the saturating ULP sum accumulator

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
clear  in  1  synchronous restart of statistics and window; pulse
in_valid  in  1  num1/num2/approx valid this cycle
num1  in  16  operand A, fp16
num2  in  16  operand B, fp16
approx  in  16  approximate product from hpm for this pair
res_valid  out  1  per-sample result strobe
res_ulp  out  15  per-sample ULP distance
res_skip  out  1  per-sample skipped flag, qualified by res_valid
sample_cnt  out  16  samples retired in window, skipped samples included
skip_cnt  out  16  skipped samples
exceed_cnt  out  16  samples with ulp > THRESH
max_ulp  out  15  maximum ulp in window
sum_ulp  out  SUM_W  saturating sum of ulp
done  out  1  window complete; sticky until clear/rst

Behaviour:
- Reset (rst=1 at a clk edge): all outputs 0, all pipeline valid bits 0. Any in-flight samples are discarded.
- clear: same effect as rst. It has priority over an in_valid in the same cycle, and that sample is dropped.
- Acceptance: a sample enters S1 only when in_valid=1 and done=0 and clear=0. The block never stalls.
- S1 (register inputs, classify): e1=num1[14:10], e2=num2[14:10].
  - skip if e1 or e2 is 0 or 31 (zero, subnormal, inf, NaN).
  - s=num1[15]^num2[15].
- S2: P = {1,num1[9:0]} * {1,num2[9:0]}, 22-bit unsigned. Exponent e = e1+e2-15, computed in 7-bit signed.
- S3 (normalise, truncate, compare):
  - If P[21]=1: mant=P[20:11], e=e+1. Otherwise: mant=P[19:10].
  - No rounding: the exact reference is round-toward-zero.
  - skip if e<1 or e>30.
  - If approx[15]≠s: ulp=15'h7FFF. Otherwise: ulp = |{e[4:0],mant} − approx[14:0]|, unsigned 15-bit.
  - If skip: ulp is forced to 0.
- Latency: res_valid/res_ulp/res_skip assert exactly 3 cycles after the accepting edge. Statistics update on the same edge as res_valid.
- Statistics update per retired sample:
  - sample_cnt+1 always.
  - If skip: skip_cnt+1 only.
  - Else: max_ulp=max(max_ulp,ulp); sum_ulp+=ulp, saturating at all-ones; exceed_cnt+1 if ulp>THRESH.
  - Counters do not wrap; WINDOW bounds them.
- Window: acceptance is counted separately with an internal accept counter. When WINDOW samples have been accepted, further in_valid is ignored.
- done asserts on the edge where sample_cnt reaches WINDOW, i.e. after the last accepted sample retires. Up to 3 samples in flight still retire after acceptance closes.
- res_valid is 0 on every cycle without a retiring sample. res_ulp/res_skip hold their last value.
- Back-to-back in_valid on every cycle gives one result per cycle with no bubbles.

Test Plan:
- 0x3C00×0x3C00, approx=0x3C00 -> after 3 clk: res_valid=1, res_ulp=0, res_skip=0; sample_cnt=1, max_ulp=0.
- 0x4000×0x4200 (2×3), approx=0x4602 -> exact 0x4600; res_ulp=2; sum_ulp=2; exceed_cnt=0 with THRESH=4.
- 0x3E00×0x3E00 (1.5×1.5=2.25, P[21]=1 path), approx=0x4080 -> exact 0x4080, ulp=0. Then approx=0xC080 -> sign mismatch, ulp=0x7FFF, exceed_cnt+1, max_ulp=0x7FFF.
- Skip cases: num1=0x7C00, num2=0x3C00; num1=0x0000; and 0x7800×0x7800 (exponent overflow) -> each gives res_skip=1, ulp 0, skip_cnt=3, max_ulp unchanged.
- 20 consecutive valid samples with WINDOW=16 -> exactly 16 retire; done=1 on the 16th retirement edge and stays 1; samples 17–20 are ignored.
- rst asserted with 2 samples in flight -> next cycle all outputs 0, no res_valid pulses follow. clear asserted with in_valid the same cycle -> that sample is dropped and sample_cnt=0.

Source files
------------

// File: rtl/hpm_err_monitor.sv
// Error monitor for the approximate fp16 multiplier: exact round-toward-zero reference, ULP distance, per-window stats.
// Result and statistics update 3 cycles after acceptance, one sample per clock; never stalls, no backpressure.
module hpm_err_monitor #(
  parameter int WINDOW = 16,
  parameter int THRESH = 4,
  parameter int SUM_W  = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             in_valid,
  input  logic [15:0]      num1,
  input  logic [15:0]      num2,
  input  logic [15:0]      approx,
  output logic             res_valid,
  output logic [14:0]      res_ulp,
  output logic             res_skip,
  output logic [15:0]      sample_cnt,
  output logic [15:0]      skip_cnt,
  output logic [15:0]      exceed_cnt,
  output logic [14:0]      max_ulp,
  output logic [SUM_W-1:0] sum_ulp,
  output logic             done
);
  localparam logic [15:0] WIN = 16'(WINDOW);
  localparam logic [14:0] THR = 15'(THRESH);

  logic              restart;
  logic              accept;
  logic [15:0]       acc_q, acc_d;

  logic              v1_q, s1_q, s1_d, skip1_q, skip1_d;
  logic [14:0]       a1_q, b1_q;
  logic [15:0]       ap1_q;

  logic              v2_q, s2_q, skip2_q;
  logic [21:0]       prod2_q, prod2_d;
  logic signed [6:0] exp2_q, exp2_d;
  logic [15:0]       ap2_q;

  logic signed [6:0] exp3;
  logic [9:0]        mant3;
  logic              skip3;
  logic [14:0]       exact3, diff3, ulp3;
  logic [SUM_W:0]    sum_ext;

  logic              res_valid_q, res_valid_d, res_skip_q, res_skip_d, done_q, done_d;
  logic [14:0]       res_ulp_q, res_ulp_d, max_q, max_d;
  logic [15:0]       sample_q, sample_d, skip_q, skip_d, exceed_q, exceed_d;
  logic [SUM_W-1:0]  sum_q, sum_d;

  assign restart = rst | clear;
  // Acceptance closes on the accept count; done only rises once the tail has retired.
  assign accept  = in_valid & ~done_q & ~clear & (acc_q < WIN);
  assign acc_d   = accept ? acc_q + 16'd1 : acc_q;

  assign skip1_d = (num1[14:10] == 5'd0) | (num1[14:10] == 5'h1F) |
                   (num2[14:10] == 5'd0) | (num2[14:10] == 5'h1F);
  assign s1_d    = num1[15] ^ num2[15];

  assign prod2_d = 22'({1'b1, a1_q[9:0]}) * 22'({1'b1, b1_q[9:0]});
  assign exp2_d  = $signed({2'b00, a1_q[14:10]} + {2'b00, b1_q[14:10]} - 7'd15);

  always_comb begin
    exp3   = prod2_q[21] ? exp2_q + 7'sd1 : exp2_q;
    mant3  = prod2_q[21] ? prod2_q[20:11] : prod2_q[19:10];
    skip3  = skip2_q | (exp3 < 7'sd1) | (exp3 > 7'sd30);
    exact3 = {exp3[4:0], mant3};
    diff3  = (exact3 >= ap2_q[14:0]) ? exact3 - ap2_q[14:0] : ap2_q[14:0] - exact3;
    if (skip3)
      ulp3 = 15'd0;
    else if (ap2_q[15] != s2_q)
      ulp3 = 15'h7FFF;
    else
      ulp3 = diff3;
  end

  always_comb begin
    res_valid_d = 1'b0;
    res_ulp_d   = res_ulp_q;
    res_skip_d  = res_skip_q;
    sample_d    = sample_q;
    skip_d      = skip_q;
    exceed_d    = exceed_q;
    max_d       = max_q;
    sum_d       = sum_q;
    done_d      = done_q;
    sum_ext     = {1'b0, sum_q} + (SUM_W+1)'(ulp3);
    if (v2_q) begin
      res_valid_d = 1'b1;
      res_ulp_d   = ulp3;
      res_skip_d  = skip3;
      sample_d    = sample_q + 16'd1;
      if (skip3) begin
        skip_d = skip_q + 16'd1;
      end else begin
        if (ulp3 > max_q) max_d = ulp3;
        sum_d = sum_ext[SUM_W] ? {SUM_W{1'b1}} : sum_ext[SUM_W-1:0];
        if (ulp3 > THR) exceed_d = exceed_q + 16'd1;
      end
      if (sample_q + 16'd1 == WIN) done_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (restart) begin
      acc_q       <= '0;
      v1_q        <= 1'b0;
      s1_q        <= 1'b0;
      skip1_q     <= 1'b0;
      a1_q        <= '0;
      b1_q        <= '0;
      ap1_q       <= '0;
      v2_q        <= 1'b0;
      s2_q        <= 1'b0;
      skip2_q     <= 1'b0;
      prod2_q     <= '0;
      exp2_q      <= '0;
      ap2_q       <= '0;
      res_valid_q <= 1'b0;
      res_ulp_q   <= '0;
      res_skip_q  <= 1'b0;
      sample_q    <= '0;
      skip_q      <= '0;
      exceed_q    <= '0;
      max_q       <= '0;
      sum_q       <= '0;
      done_q      <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      v1_q        <= accept;
      s1_q        <= s1_d;
      skip1_q     <= skip1_d;
      a1_q        <= num1[14:0];
      b1_q        <= num2[14:0];
      ap1_q       <= approx;
      v2_q        <= v1_q;
      s2_q        <= s1_q;
      skip2_q     <= skip1_q;
      prod2_q     <= prod2_d;
      exp2_q      <= exp2_d;
      ap2_q       <= ap1_q;
      res_valid_q <= res_valid_d;
      res_ulp_q   <= res_ulp_d;
      res_skip_q  <= res_skip_d;
      sample_q    <= sample_d;
      skip_q      <= skip_d;
      exceed_q    <= exceed_d;
      max_q       <= max_d;
      sum_q       <= sum_d;
      done_q      <= done_d;
    end
  end

  assign res_valid  = res_valid_q;
  assign res_ulp    = res_ulp_q;
  assign res_skip   = res_skip_q;
  assign sample_cnt = sample_q;
  assign skip_cnt   = skip_q;
  assign exceed_cnt = exceed_q;
  assign max_ulp    = max_q;
  assign sum_ulp    = sum_q;
  assign done       = done_q;
endmodule
